// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract.
// Each runs on operand magnitudes for WIDTH cycles, followed by one sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one edge
// CALC  | one radix-2 step per cycle, WIDTH steps
// FIX   | sign correction and HI/LO commit
// DONE  | one-cycle done pulse; div_zero valid here
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;     // product sign, or quotient sign
  logic             neg_r;     // remainder sign: follows the dividend
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc;       // product high half, or partial remainder
  logic [WIDTH-1:0] qr;        // multiplier shifting out, or quotient shifting in

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand magnitudes and signs at issue; op[0]=1 selects unsigned forms
  always_comb begin
    a_neg  = ~op[0] & portA[WIDTH-1];
    b_neg  = ~op[0] & portB[WIDTH-1];
    a_mag  = a_neg ? (~portA + 1'b1) : portA;
    b_mag  = b_neg ? (~portB + 1'b1) : portB;
    b_zero = (portB == '0);
  end

  // One radix-2 step of each algorithm, plus the sign-corrected results
  always_comb begin
    mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc, qr[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift - {1'b0, mag_b};
    prod      = {acc, qr};
    prod_fix  = neg_q ? (~prod + 1'b1) : prod;
    quot_fix  = neg_q ? (~qr + 1'b1) : qr;
    rem_fix   = neg_r ? (~acc + 1'b1) : acc;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      qr       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start && !flush) begin
            if (op[2:1] == 2'b10) begin
              if (op[0]) lo <= portA;
              else       hi <= portA;
            end else if (!op[2]) begin
              if (op[1] && b_zero) begin
                // Divide by zero: skip the iteration, leave HI/LO alone
                state    <= DONE;
                done     <= 1'b1;
                div_zero <= 1'b1;
              end else begin
                state  <= CALC;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                mag_b  <= b_mag;
                acc    <= '0;
                qr     <= a_mag;
              end
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              qr  <= {qr[WIDTH-2:0], div_ge};
            end else begin
              acc <= mul_sum[WIDTH:1];
              qr  <= {mul_sum[0], qr[WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (flush) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] portA = '0;
  logic [31:0] portB = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .flush(flush), .op(op),
    .portA(portA), .portB(portB), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] p;
    rh = m_hi;
    rl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      3'd3: if (b != 0) begin rl = a / b; rh = a % b; end
      3'd4: rh = a;
      3'd5: rl = a;
      default: ;
    endcase
  endtask

  // Called at the first negedge after the accepting edge (cycle 1);
  // returns the cycle number on which done is seen.
  task automatic wait_done(output int cyc, output int gaps);
    cyc  = 1;
    gaps = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) gaps++;
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic check_done(input string tag, input int cyc, input int gaps, input logic dz);
    check({tag, "_lat"}, 64'(cyc), dz ? 64'd1 : 64'd34);
    check({tag, "_busy_gap"}, 64'(gaps), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_dz"}, 64'(div_zero), 64'(dz));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(negedge CLK);
    check({tag, "_pulse"}, {62'd0, done, div_zero}, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] eh, el;
    int cyc, gaps;
    logic dz;
    model(o, a, b, eh, el);
    dz = (o[2:1] == 2'b01) && (b == 0);
    @(negedge CLK);
    start = 1'b1; op = o; portA = a; portB = b;
    @(negedge CLK);
    start = 1'b0; op = 3'($urandom); portA = $urandom; portB = $urandom;
    m_hi = eh;
    m_lo = el;
    if (o[2]) begin
      check({tag, "_mt_flags"}, {62'd0, busy, done}, 64'd0);
      check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    end else begin
      wait_done(cyc, gaps);
      check_done(tag, cyc, gaps, dz);
    end
  endtask

  initial begin
    int cyc, gaps, dcount;
    logic [31:0] ra, rb;
    logic [2:0] ro;

    #12;
    check("reset_state", {29'd0, busy, done, div_zero, hi, lo}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    do_op("mthi", 3'd4, 32'hAAAA_0001, 32'd0);
    do_op("mtlo", 3'd5, 32'h5555_0002, 32'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge CLK);
    start = 1'b1; op = 3'd0; portA = 32'd123; portB = 32'd456;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("rst_mid_calc", {30'd0, busy, done, hi}, 64'd0);
    check("rst_mid_calc_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge CLK);
    nRST = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    check("multu_val", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu", 3'd3, 32'd7, 32'd2);
    check("divu_val", {hi, lo}, 64'h0000_0001_0000_0003);

    do_op("pre_hi", 3'd4, 32'h1234, 32'd0);
    do_op("pre_lo", 3'd5, 32'h5678, 32'd0);
    do_op("div0", 3'd2, 32'd99, 32'd0);
    check("div0_val", {hi, lo}, 64'h0000_1234_0000_5678);

    // flush beats start in IDLE, even for MTHI
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 3'd4; portA = 32'hDEAD_BEEF;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_mthi", {hi, lo}, {m_hi, m_lo});

    // flush during CALC cycle 20: back to IDLE, no done, HI/LO untouched
    @(negedge CLK);
    start = 1'b1; op = 3'd0; portA = 32'd1000; portB = 32'd77;
    @(negedge CLK);
    start = 1'b0;
    repeat (19) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_calc_busy", 64'(busy), 64'd0);
    dcount = 0;
    repeat (40) begin @(negedge CLK); if (done === 1'b1) dcount++; end
    check("flush_calc_no_done", 64'(dcount), 64'd0);
    check("flush_calc_hilo", {hi, lo}, {m_hi, m_lo});

    // start held high while busy: a single operation, a single done
    model(3'd1, 32'h0001_0000, 32'h0003_0000, ra, rb);
    @(negedge CLK);
    start = 1'b1; op = 3'd1; portA = 32'h0001_0000; portB = 32'h0003_0000;
    @(negedge CLK);
    portA = 32'd5; portB = 32'd6;
    wait_done(cyc, gaps);
    start = 1'b0;
    m_hi = ra; m_lo = rb;
    check_done("held_start", cyc, gaps, 1'b0);
    dcount = 0;
    repeat (40) begin @(negedge CLK); if (done === 1'b1) dcount++; end
    check("held_start_one_done", 64'(dcount), 64'd0);

    // Overflow divide, then back-to-back issue with start held through DONE
    model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ra, rb);
    @(negedge CLK);
    start = 1'b1; op = 3'd2; portA = 32'h8000_0000; portB = 32'hFFFF_FFFF;
    @(negedge CLK);
    wait_done(cyc, gaps);
    op = 3'd3; portA = 32'd100; portB = 32'd7;
    m_hi = ra; m_lo = rb;
    check("ovf_lat", 64'(cyc), 64'd34);
    check("ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);
    @(negedge CLK);
    check("b2b_idle_gap", {62'd0, busy, done}, 64'd0);
    @(negedge CLK);
    start = 1'b0;
    check("b2b_accept", 64'(busy), 64'd1);
    model(3'd3, 32'd100, 32'd7, ra, rb);
    m_hi = ra; m_lo = rb;
    wait_done(cyc, gaps);
    check_done("b2b", cyc, gaps, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (ro == 3'd6) begin
        @(negedge CLK);
        start = 1'b1; op = 3'b110 | 3'($urandom_range(0, 1)); portA = ra; portB = rb;
        @(negedge CLK);
        start = 1'b0;
        check("rand_nop", {30'd0, busy, done, hi, lo} >> 0, {32'd0, m_hi, m_lo} >> 0);
      end else begin
        do_op($sformatf("rand%0d", i), ro, ra, rb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
